clause_loader: RTL and testbench

- Front-end writer for the clause database. Accepts a serial stream of signed literals, one per beat, with a last-literal flag on each clause. Packs each clause into the database push format (mask, pole, var slots) and issues one push per clause.
- Sits between the formula input path (host/DIMACS feeder) and the clause database push port.
- Removes duplicate literals and discards tautological clauses.
- Reports overflow, database-full and truncation errors.

---
 rtl/sat_pkg.sv | 38 +++
 rtl/clause_dup_check.sv | 24 ++
 rtl/clause_loader.sv | 151 +++++++++++++++
 tb/tb_clause_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared types and sizing for the clause-database front end.
`ifndef VAR_PER_CLAUSE
`define VAR_PER_CLAUSE 5
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

package sat_pkg;
   localparam int VAR_PER_CLAUSE   = `VAR_PER_CLAUSE;
   localparam int MAX_VARS_BITS    = `MAX_VARS_BITS;
   localparam int MAX_CLAUSES_BITS = `MAX_CLAUSES_BITS;
   localparam int CNT_BITS         = $clog2(VAR_PER_CLAUSE + 1);

   localparam logic [CNT_BITS-1:0] SLOT_MAX = CNT_BITS'(VAR_PER_CLAUSE);

   typedef struct packed {
      logic [MAX_VARS_BITS-1:0] vid;
      logic                     neg;
   } literal_t;

   // Field order mirrors the database push port: slot 0 sits in the low bits.
   typedef struct packed {
      logic [VAR_PER_CLAUSE-1:0]                    mask;
      logic [VAR_PER_CLAUSE-1:0]                    pole;
      logic [VAR_PER_CLAUSE-1:0][MAX_VARS_BITS-1:0] vid;
   } clause_t;

   typedef enum logic [1:0] {ACCUM, PUSH, DONE, ERR} loader_state_t;
   typedef enum logic [1:0] {NONE, OVERFLOW, DB_FULL, TRUNC} loader_err_t;

   function automatic logic [MAX_CLAUSES_BITS:0] sat_inc(input logic [MAX_CLAUSES_BITS:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/clause_dup_check.sv
// Compares one incoming literal against every occupied slot of the clause being built.
// Purely combinational; no backpressure of its own.
module clause_dup_check
   import sat_pkg::*;
(
   input  clause_t  slots,
   input  literal_t lit,
   output logic     dup,
   output logic     taut
);
   always_comb begin
      dup  = 1'b0;
      taut = 1'b0;
      for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
         if (slots.mask[i] && (slots.vid[i] == lit.vid)) begin
            // pole is 1 for a positive literal, so equal pole/neg means opposite sign
            if (slots.pole[i] == lit.neg)
               taut = 1'b1;
            else
               dup = 1'b1;
         end
      end
   end
endmodule

// File: rtl/clause_loader.sv
// Packs a literal stream into one database push per clause, dropping duplicates and tautologies.
// Push lands the cycle after the last beat; lit_ready drops during the push and in DONE/ERR.
module clause_loader
   import sat_pkg::*;
(
   input  logic                                         clock,
   input  logic                                         reset,
   input  logic                                         lit_valid,
   output logic                                         lit_ready,
   input  logic [MAX_VARS_BITS-1:0]                     lit_var,
   input  logic                                         lit_neg,
   input  logic                                         lit_last,
   input  logic                                         stream_end,
   output logic                                         db_push,
   output logic [VAR_PER_CLAUSE-1:0]                    db_mask,
   output logic [VAR_PER_CLAUSE-1:0]                    db_pole,
   output logic [VAR_PER_CLAUSE-1:0][MAX_VARS_BITS-1:0] db_var,
   input  logic                                         db_full,
   output logic [MAX_CLAUSES_BITS:0]                    clause_count,
   output logic [MAX_CLAUSES_BITS:0]                    taut_count,
   output logic                                         done,
   output logic                                         error,
   output logic [1:0]                                   err_code
);
   loader_state_t             state_q, state_d;
   clause_t                   slots_q, slots_d;
   logic [CNT_BITS-1:0]       cnt_q, cnt_d;
   logic                      taut_q, taut_d;
   logic                      pend_q, pend_d;
   loader_err_t               err_q, err_d;
   logic [MAX_CLAUSES_BITS:0] ccnt_q, ccnt_d;
   logic [MAX_CLAUSES_BITS:0] tcnt_q, tcnt_d;

   literal_t lit;
   logic     hit_dup, hit_taut;
   logic     xfer, taut_now, ovf;

   assign lit = '{vid: lit_var, neg: lit_neg};

   clause_dup_check u_dup (
      .slots (slots_q),
      .lit   (lit),
      .dup   (hit_dup),
      .taut  (hit_taut)
   );

   assign xfer = lit_valid && (state_q == ACCUM);

   always_comb begin
      state_d  = state_q;
      slots_d  = slots_q;
      cnt_d    = cnt_q;
      taut_d   = taut_q;
      pend_d   = pend_q;
      err_d    = err_q;
      ccnt_d   = ccnt_q;
      tcnt_d   = tcnt_q;
      taut_now = taut_q;
      ovf      = 1'b0;
      case (state_q)
         ACCUM: begin
            if (xfer) begin
               if (hit_taut)
                  taut_now = 1'b1;
               else if (!hit_dup) begin
                  if (cnt_q < SLOT_MAX) begin
                     slots_d.vid[cnt_q]  = lit_var;
                     slots_d.pole[cnt_q] = ~lit_neg;
                     slots_d.mask[cnt_q] = 1'b1;
                     cnt_d               = cnt_q + 1'b1;
                  end else
                     ovf = 1'b1;
               end
            end
            if (ovf) begin
               state_d = ERR;
               err_d   = OVERFLOW;
            end else if (xfer && lit_last) begin
               if (taut_now) begin
                  slots_d = '0;
                  cnt_d   = '0;
                  taut_d  = 1'b0;
                  tcnt_d  = sat_inc(tcnt_q);
                  if (stream_end)
                     state_d = DONE;
               end else begin
                  state_d = PUSH;
                  pend_d  = stream_end;
               end
            end else begin
               taut_d = taut_now;
               if (stream_end) begin
                  if (!xfer && (cnt_q == '0) && !taut_q)
                     state_d = DONE;
                  else begin
                     state_d = ERR;
                     err_d   = TRUNC;
                  end
               end
            end
         end
         PUSH: begin
            if (db_full) begin
               state_d = ERR;
               err_d   = DB_FULL;
            end else begin
               ccnt_d  = sat_inc(ccnt_q);
               slots_d = '0;
               cnt_d   = '0;
               pend_d  = 1'b0;
               state_d = (pend_q || stream_end) ? DONE : ACCUM;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ACCUM;
         slots_q <= '0;
         cnt_q   <= '0;
         taut_q  <= 1'b0;
         pend_q  <= 1'b0;
         err_q   <= NONE;
         ccnt_q  <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         slots_q <= slots_d;
         cnt_q   <= cnt_d;
         taut_q  <= taut_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
         ccnt_q  <= ccnt_d;
         tcnt_q  <= tcnt_d;
      end
   end

   // Reset squashes a push already in flight, so the database never sees a partial clause.
   assign db_push      = (state_q == PUSH) && !db_full && !reset;
   assign db_mask      = db_push ? slots_q.mask : '0;
   assign db_pole      = db_push ? slots_q.pole : '0;
   assign db_var       = db_push ? slots_q.vid  : '0;
   assign lit_ready    = (state_q == ACCUM);
   assign done         = (state_q == DONE);
   assign error        = (state_q == ERR);
   assign err_code     = err_q;
   assign clause_count = ccnt_q;
   assign taut_count   = tcnt_q;
endmodule

// File: tb/tb_clause_loader.sv
// Directed bench for clause_loader with hand-computed expectations.
module tb_clause_loader;
   import sat_pkg::*;

   logic                                         clock = 1'b0;
   logic                                         reset = 1'b1;
   logic                                         lit_valid = 1'b0;
   logic                                         lit_ready;
   logic [MAX_VARS_BITS-1:0]                     lit_var = '0;
   logic                                         lit_neg = 1'b0;
   logic                                         lit_last = 1'b0;
   logic                                         stream_end = 1'b0;
   logic                                         db_push;
   logic [VAR_PER_CLAUSE-1:0]                    db_mask;
   logic [VAR_PER_CLAUSE-1:0]                    db_pole;
   logic [VAR_PER_CLAUSE-1:0][MAX_VARS_BITS-1:0] db_var;
   logic                                         db_full = 1'b0;
   logic [MAX_CLAUSES_BITS:0]                    clause_count;
   logic [MAX_CLAUSES_BITS:0]                    taut_count;
   logic                                         done;
   logic                                         error;
   logic [1:0]                                   err_code;

   int checks = 0;
   int errors = 0;
   int pushes = 0;

   clause_loader dut (
      .clock        (clock),
      .reset        (reset),
      .lit_valid    (lit_valid),
      .lit_ready    (lit_ready),
      .lit_var      (lit_var),
      .lit_neg      (lit_neg),
      .lit_last     (lit_last),
      .stream_end   (stream_end),
      .db_push      (db_push),
      .db_mask      (db_mask),
      .db_pole      (db_pole),
      .db_var       (db_var),
      .db_full      (db_full),
      .clause_count (clause_count),
      .taut_count   (taut_count),
      .done         (done),
      .error        (error),
      .err_code     (err_code)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (db_push === 1'b1) pushes++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic beat(input int v, input logic n, input logic l, input logic se);
      lit_valid  = 1'b1;
      lit_var    = MAX_VARS_BITS'(v);
      lit_neg    = n;
      lit_last   = l;
      stream_end = se;
      tick();
      lit_valid  = 1'b0;
      lit_last   = 1'b0;
      stream_end = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic end_pulse();
      stream_end = 1'b1;
      tick();
      stream_end = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      chk("rst_ready", lit_ready, 1);
      chk("rst_push", db_push, 0);
      chk("rst_mask", db_mask, 0);
      chk("rst_ccnt", clause_count, 0);
      chk("rst_tcnt", taut_count, 0);
      chk("rst_done", done, 0);
      chk("rst_err", {error, err_code}, 0);

      // basic clause: push lands the cycle after the last beat
      beat(3, 0, 0, 0);
      beat(7, 1, 0, 0);
      chk("c1_no_early_push", db_push, 0);
      beat(12, 0, 1, 0);
      chk("c1_push", db_push, 1);
      chk("c1_mask", db_mask, 5'b00111);
      chk("c1_pole", db_pole, 5'b00101);
      chk("c1_var", db_var, 40'h00000c0703);
      chk("c1_ready_low", lit_ready, 0);
      tick();
      chk("c1_ccnt", clause_count, 1);
      chk("c1_push_gone", db_push, 0);
      chk("c1_mask_zero", db_mask, 0);
      chk("c1_ready", lit_ready, 1);

      // duplicate literal dropped
      beat(4, 0, 0, 0);
      beat(4, 0, 0, 0);
      beat(9, 1, 1, 0);
      chk("c2_mask", db_mask, 5'b00011);
      chk("c2_pole", db_pole, 5'b00001);
      chk("c2_var", db_var, 40'h0000000904);
      tick();
      chk("c2_ccnt", clause_count, 2);
      chk("c2_pushes", pushes, 2);

      // tautology discarded, next clause starts clean
      beat(5, 0, 0, 0);
      beat(6, 0, 0, 0);
      beat(5, 1, 1, 0);
      chk("t_no_push", db_push, 0);
      chk("t_ready", lit_ready, 1);
      chk("t_tcnt", taut_count, 1);
      beat(1, 0, 1, 0);
      chk("t_next_mask", db_mask, 5'b00001);
      chk("t_next_pole", db_pole, 5'b00001);
      chk("t_next_var", db_var, 40'h0000000001);
      tick();
      chk("t_ccnt", clause_count, 3);
      chk("t_pushes", pushes, 3);

      // overflow on the sixth distinct literal
      do_reset();
      chk("r_ccnt", clause_count, 0);
      for (int i = 1; i <= 5; i++) beat(i, 0, 0, 0);
      chk("ovf_five_ok", error, 0);
      beat(6, 0, 0, 0);
      chk("ovf_err", error, 1);
      chk("ovf_code", err_code, 1);
      chk("ovf_ready", lit_ready, 0);
      end_pulse();
      tick();
      chk("ovf_frozen", err_code, 1);
      chk("ovf_done", done, 0);
      chk("ovf_pushes", pushes, 3);

      // database full
      do_reset();
      db_full = 1'b1;
      beat(2, 0, 1, 0);
      chk("full_no_push", db_push, 0);
      tick();
      db_full = 1'b0;
      chk("full_err", error, 1);
      chk("full_code", err_code, 2);
      tick();
      chk("full_pushes", pushes, 3);

      // truncated clause
      do_reset();
      beat(1, 0, 0, 0);
      end_pulse();
      chk("trunc_err", error, 1);
      chk("trunc_code", err_code, 3);

      // empty stream goes straight to done
      do_reset();
      end_pulse();
      chk("empty_done", done, 1);
      chk("empty_err", error, 0);

      // stream_end coincides with the final lit_last
      do_reset();
      beat(1, 0, 1, 0);
      chk("se_push1", db_push, 1);
      tick();
      beat(2, 1, 1, 1);
      chk("se_push2", db_push, 1);
      chk("se_pole2", db_pole, 5'b00000);
      chk("se_not_done_yet", done, 0);
      tick();
      chk("se_done", done, 1);
      chk("se_ccnt", clause_count, 2);
      chk("se_ready", lit_ready, 0);
      tick();
      chk("se_done_held", done, 1);
      chk("se_pushes", pushes, 5);

      // reset during the push cycle suppresses the push
      do_reset();
      beat(8, 0, 1, 0);
      reset = 1'b1;
      #1;
      chk("rp_no_push", db_push, 0);
      tick();
      reset = 1'b0;
      chk("rp_ccnt", clause_count, 0);
      chk("rp_mask", db_mask, 0);
      chk("rp_ready", lit_ready, 1);
      chk("rp_done", done, 0);
      tick();
      chk("rp_pushes", pushes, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
